// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one uart transmitter among NUM_REQ byte producers
module uart_tx_sched #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           uart_byte,
   output logic                 uart_start,
   input  logic                 uart_done,
   output logic                 busy,
   output logic [2:0]           grant_id,
   output logic                 timeout
);

   localparam int             TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  WD_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam logic [2:0]     RR_INIT  = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    last_q, last_d, grant_q, grant_d, win;
   logic [7:0]    byte_q, byte_d, gap_q, gap_d;
   logic [TW-1:0] wdog_q, wdog_d;
   logic [7:0]    valid_ext;
   logic [63:0]   data_ext;
   logic          any_valid;

   assign valid_ext  = 8'(req_valid);
   assign data_ext   = 64'(req_data);
   assign any_valid  = |req_valid;
   assign uart_byte  = byte_q;
   assign grant_id   = grant_q;
   assign busy       = state_q != IDLE;
   assign uart_start = state_q == START;
   assign timeout    = state_q == WAIT_DONE && !uart_done && wdog_q == WD_LAST;
   assign req_ready  = (rst && state_q == IDLE && any_valid) ? NUM_REQ'(1) << win : '0;

   // Pick the first valid requester after the last grant; descending loop so the nearest one wins.
   always_comb begin
      win = last_q;
      for (int k = NUM_REQ; k >= 1; k--)
         if (valid_ext[3'((int'(last_q) + k) % NUM_REQ)]) win = 3'((int'(last_q) + k) % NUM_REQ);
   end

   // Next-state logic: grant, start pulse, wait for done or watchdog, optional gap.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      byte_d  = byte_q;
      wdog_d  = wdog_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: if (any_valid) begin
            state_d = START;
            last_d  = win;
            grant_d = win;
            byte_d  = data_ext[{win, 3'b000} +: 8];
         end
         START: begin
            wdog_d  = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            wdog_d = wdog_q + 1'b1;
            gap_d  = '0;
            if (uart_done) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            else if (wdog_q == WD_LAST) state_d = IDLE;
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= RR_INIT;
         grant_q <= '0;
         byte_q  <= '0;
         wdog_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         byte_q  <= byte_d;
         wdog_q  <= wdog_d;
         gap_q   <= gap_d;
      end
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart transmitter among NUM_REQ byte producers.
- Accepts one byte per valid/ready handshake and presents it to the transmitter. It pulses start, then waits for the transmitter's done.
- Optionally enforces an inter-frame gap, and watchdogs a transmitter that never reports done.
- Sits between on-chip byte sources (debug printers, status reporters) and the single uart instance driving the board tx pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clk cycles inserted after each done before the next grant (0..255).
- TIMEOUT_CYCLES, 1024, max clk cycles waited for uart_done before abort (>=16).

Ports:
- clk  input  1  single clock; the uart transmitter is clocked by the same clk.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NUM_REQ  per-requester byte-available flag.
- req_data  input  8*NUM_REQ  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  output  NUM_REQ  per-requester accept strobe; transfer occurs when valid&ready are both high.
- uart_byte  output  8  byte presented to the transmitter; held stable from the START state until leaving WAIT_DONE.
- uart_start  output  1  one-cycle start pulse to the transmitter.
- uart_done  input  1  one-cycle pulse from the transmitter when the stop bit completes.
- busy  output  1  high in every state except IDLE.
- grant_id  output  3  index of the requester currently being served; holds the last value in IDLE.
- timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE; req_ready=0; uart_start=0; uart_byte=0; busy=0; grant_id=0; timeout=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Internal counters=0.
- Arbitration: search begins at (last_grant+1) mod NUM_REQ and wraps. The first set req_valid bit wins.
- States:
  - IDLE: if any req_valid, req_ready[winner]=1 combinationally this cycle, and only that bit. Then:
    - latch req_data slice into uart_byte;
    - grant_id<=winner; last_grant<=winner;
    - go to START.
    - If no req_valid, stay in IDLE with req_ready=0.
  - START: uart_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT_DONE.
  - WAIT_DONE: the counter increments each cycle.
    - If uart_done=1: go to GAP if GAP_CYCLES>0, else IDLE.
    - Else if counter reaches TIMEOUT_CYCLES-1: timeout=1 for one cycle, go to IDLE. The byte is dropped and not retried.
    - If uart_done and the timeout condition occur in the same cycle, done wins and no timeout pulse is issued.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency:
  - req_valid seen in IDLE at cycle t → handshake at t, uart_start at t+1.
  - Minimum spacing between uart_start pulses = frame time + GAP_CYCLES + 2 cycles.
- uart_done outside WAIT_DONE is ignored.
- req_ready is never asserted outside IDLE.
- A requester dropping valid before handshake loses nothing, since no transfer has occurred.
- req_data changes after handshake do not affect uart_byte.
- Reset mid-frame aborts immediately, with all outputs at reset values. The uart is expected to be reset by the same rst.

Test Plan:
- Single requester: req_valid[0]=1, req_data=0x30, uart_done pulsed 40 cycles after start → req_ready[0] high 1 cycle, uart_start high at the next cycle, uart_byte=0x30 until done, busy=1 throughout, back to IDLE the cycle after done.
- Fairness, NUM_REQ=4, all valid continuously with bytes 0x41..0x44 → grant order 0,1,2,3,0,1; exactly one start per done; no requester served twice before all others are served.
- Sparse requests: only req_valid[2] and req_valid[0] set, last_grant=2 → grant 0 then 2, alternating.
- GAP_CYCLES=5 → 5 idle cycles (busy=1, req_ready=0) after each done before the next req_ready pulse.
- Watchdog, TIMEOUT_CYCLES=16, uart_done never pulsed → timeout pulse exactly 16 cycles after uart_start, state back to IDLE, next requester served. Also drive done and the timeout condition in the same cycle → no timeout pulse.
- Assert rst=0 during WAIT_DONE → outputs zero asynchronously. After release with all requesters valid, first grant goes to requester 0.
